// File: rtl/zeroheti_dbg_sba_bridge.sv
// Debug-module SBA to OBI bridge.
// Accepts single word accesses from the debug module master port and issues them
// as OBI transactions, one outstanding at a time. Accesses that hit the debug
// module's own address window are refused without touching the bus. A timeout
// aborts stalled accesses towards the debug module. The bus side is then drained
// in the background so the OBI handshake is still completed.
module zeroheti_dbg_sba_bridge #(
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          DataWidth     = 32,
    parameter logic [AddrWidth-1:0] DbgBase       = AddrWidth'(32'h1A11_0000),
    parameter logic [AddrWidth-1:0] DbgSize       = AddrWidth'(32'h0000_1000),
    parameter int unsigned          TimeoutCycles = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   dm_req_i,
    input  logic [AddrWidth-1:0]   dm_addr_i,
    input  logic                   dm_we_i,
    input  logic [DataWidth/8-1:0] dm_be_i,
    input  logic [DataWidth-1:0]   dm_wdata_i,
    output logic                   dm_gnt_o,
    output logic                   dm_rvalid_o,
    output logic [DataWidth-1:0]   dm_rdata_o,
    output logic                   dm_err_o,
    output logic                   dm_other_err_o,
    output logic                   obi_req_o,
    input  logic                   obi_gnt_i,
    output logic [AddrWidth-1:0]   obi_addr_o,
    output logic                   obi_we_o,
    output logic [DataWidth/8-1:0] obi_be_o,
    output logic [DataWidth-1:0]   obi_wdata_o,
    input  logic                   obi_rvalid_i,
    input  logic [DataWidth-1:0]   obi_rdata_i,
    input  logic                   obi_err_i
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned CntWidth = $clog2(TimeoutCycles) + 1;
    // The abort decision is taken in the cycle whose counter value is TimeoutCycles-2,
    // i.e. when the post-increment count reaches TimeoutCycles-1.
    localparam logic [CntWidth-1:0] CntLimit = CntWidth'(TimeoutCycles - 2);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT_R,
        RESP,
        DRAIN_A,
        DRAIN_R
    } state_e;

    state_e               state_reg, state_next;
    logic [CntWidth-1:0]  cnt_reg, cnt_next;
    logic [AddrWidth-1:0] addr_reg, addr_next;
    logic                 we_reg, we_next;
    logic [BeWidth-1:0]   be_reg, be_next;
    logic [DataWidth-1:0] wdata_reg, wdata_next;
    logic                 req_reg, req_next;
    logic                 rvalid_reg, rvalid_next;
    logic [DataWidth-1:0] rdata_reg, rdata_next;
    logic                 err_reg, err_next;
    logic                 other_err_reg, other_err_next;

    logic [AddrWidth-1:0] dm_offset;
    logic                 in_window;
    logic                 timeout;
    logic                 abort;

    // Offset from the window base; addresses below the base wrap to large values.
    assign dm_offset = dm_addr_i - DbgBase;
    assign in_window = (dm_offset < DbgSize);
    assign timeout   = (cnt_reg == CntLimit);

    // Next-state, capture and response decisions.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        addr_next      = addr_reg;
        we_next        = we_reg;
        be_next        = be_reg;
        wdata_next     = wdata_reg;
        rvalid_next    = 1'b0;
        rdata_next     = rdata_reg;
        err_next       = err_reg;
        other_err_next = other_err_reg;
        dm_gnt_o       = 1'b0;
        abort          = 1'b0;

        case (state_reg)
            IDLE: begin
                dm_gnt_o = dm_req_i;
                if (dm_req_i) begin
                    addr_next  = {dm_addr_i[AddrWidth-1:2], 2'b00};
                    we_next    = dm_we_i;
                    be_next    = dm_be_i;
                    wdata_next = dm_wdata_i;
                    if (in_window) begin
                        state_next = RESP;
                        abort      = 1'b1;
                    end else begin
                        state_next = ADDR;
                        cnt_next   = '0;
                    end
                end
            end
            ADDR: begin
                cnt_next = cnt_reg + 1'b1;
                if (obi_gnt_i) begin
                    // A grant coinciding with the abort still owes a response beat.
                    state_next = timeout ? DRAIN_R : WAIT_R;
                    abort      = timeout;
                end else if (timeout) begin
                    state_next = DRAIN_A;
                    abort      = 1'b1;
                end
            end
            WAIT_R: begin
                cnt_next = cnt_reg + 1'b1;
                if (obi_rvalid_i) begin
                    state_next     = RESP;
                    rvalid_next    = 1'b1;
                    rdata_next     = we_reg ? '0 : obi_rdata_i;
                    err_next       = obi_err_i;
                    other_err_next = 1'b0;
                end else if (timeout) begin
                    state_next = DRAIN_R;
                    abort      = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            DRAIN_A: begin
                if (obi_gnt_i) begin
                    state_next = DRAIN_R;
                end
            end
            DRAIN_R: begin
                if (obi_rvalid_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Refused or aborted accesses answer with other_err and no data.
        if (abort) begin
            rvalid_next    = 1'b1;
            rdata_next     = '0;
            err_next       = 1'b0;
            other_err_next = 1'b1;
        end

        // The request stays up in every state that still owes the bus an address phase.
        req_next = (state_next == ADDR) || (state_next == DRAIN_A);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            we_reg        <= 1'b0;
            be_reg        <= '0;
            wdata_reg     <= '0;
            req_reg       <= 1'b0;
            rvalid_reg    <= 1'b0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
            other_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            we_reg        <= we_next;
            be_reg        <= be_next;
            wdata_reg     <= wdata_next;
            req_reg       <= req_next;
            rvalid_reg    <= rvalid_next;
            rdata_reg     <= rdata_next;
            err_reg       <= err_next;
            other_err_reg <= other_err_next;
        end
    end

    assign dm_rvalid_o    = rvalid_reg;
    assign dm_rdata_o     = rdata_reg;
    assign dm_err_o       = err_reg;
    assign dm_other_err_o = other_err_reg;
    assign obi_req_o      = req_reg;
    assign obi_addr_o     = addr_reg;
    assign obi_we_o       = we_reg;
    assign obi_be_o       = be_reg;
    assign obi_wdata_o    = wdata_reg;

endmodule

// File: tb/tb_zeroheti_dbg_sba_bridge.sv
// Bench for the SBA to OBI bridge: directed scenarios plus randomized accesses,
// each predicted with closed-form timing from a transaction-level model.
module tb_zeroheti_dbg_sba_bridge;

    localparam int          T        = 16;
    localparam logic [31:0] DBG_BASE = 32'h1A11_0000;
    localparam logic [31:0] DBG_SIZE = 32'h0000_1000;

    logic        clk_i;
    logic        rst_i;
    logic        dm_req_i;
    logic [31:0] dm_addr_i;
    logic        dm_we_i;
    logic [3:0]  dm_be_i;
    logic [31:0] dm_wdata_i;
    logic        dm_gnt_o;
    logic        dm_rvalid_o;
    logic [31:0] dm_rdata_o;
    logic        dm_err_o;
    logic        dm_other_err_o;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;

    int n_checks = 0;
    int n_pass   = 0;

    zeroheti_dbg_sba_bridge #(
        .AddrWidth    (32),
        .DataWidth    (32),
        .DbgBase      (DBG_BASE),
        .DbgSize      (DBG_SIZE),
        .TimeoutCycles(T)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .dm_req_i      (dm_req_i),
        .dm_addr_i     (dm_addr_i),
        .dm_we_i       (dm_we_i),
        .dm_be_i       (dm_be_i),
        .dm_wdata_i    (dm_wdata_i),
        .dm_gnt_o      (dm_gnt_o),
        .dm_rvalid_o   (dm_rvalid_o),
        .dm_rdata_o    (dm_rdata_o),
        .dm_err_o      (dm_err_o),
        .dm_other_err_o(dm_other_err_o),
        .obi_req_o     (obi_req_o),
        .obi_gnt_i     (obi_gnt_i),
        .obi_addr_o    (obi_addr_o),
        .obi_we_o      (obi_we_o),
        .obi_be_o      (obi_be_o),
        .obi_wdata_o   (obi_wdata_o),
        .obi_rvalid_i  (obi_rvalid_i),
        .obi_rdata_i   (obi_rdata_i),
        .obi_err_i     (obi_err_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit in_dbg(input logic [31:0] a);
        longint unsigned la = a;
        longint unsigned lo = DBG_BASE;
        longint unsigned hi = longint'(DBG_BASE) + longint'(DBG_SIZE);
        return (la >= lo) && (la < hi);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, ".gnt"},       32'(dm_gnt_o),       32'd0);
        chk({tag, ".rvalid"},    32'(dm_rvalid_o),    32'd0);
        chk({tag, ".rdata"},     dm_rdata_o,          32'd0);
        chk({tag, ".err"},       32'(dm_err_o),       32'd0);
        chk({tag, ".other_err"}, 32'(dm_other_err_o), 32'd0);
        chk({tag, ".obi_req"},   32'(obi_req_o),      32'd0);
        chk({tag, ".obi_addr"},  obi_addr_o,          32'd0);
        chk({tag, ".obi_we"},    32'(obi_we_o),       32'd0);
        chk({tag, ".obi_be"},    32'(obi_be_o),       32'd0);
        chk({tag, ".obi_wdata"}, obi_wdata_o,         32'd0);
    endtask

    // One access. The target grants g cycles after the request first appears and
    // answers r (>=1) cycles after the grant. Cycle 0 is the dm_gnt_o cycle.
    // The DM keeps requesting until the bridge is free again, so grants must stay low.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata, input int g, input int r,
                           input logic [31:0] rd, input logic er);
        bit  forb   = in_dbg(addr);
        int  k_gnt  = 1 + g;
        int  k_rv   = 1 + g + r;
        bit  tmo    = !forb && (k_rv > T - 1);
        int  resp_k = forb ? 1 : (tmo ? T : k_rv + 1);
        int  last   = forb ? 1 : (tmo ? k_rv : k_rv + 1);
        logic [31:0] exp_rdata = (forb || tmo || we) ? 32'd0 : rd;
        logic        exp_err   = !forb && !tmo && er;
        bit          exp_req;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk_i);
            #1;
            dm_req_i     = 1'b1;
            dm_addr_i    = addr;
            dm_we_i      = we;
            dm_be_i      = be;
            dm_wdata_i   = wdata;
            obi_gnt_i    = !forb && (k == k_gnt);
            obi_rvalid_i = !forb && (k == k_rv);
            obi_rdata_i  = (k == k_rv) ? rd : $urandom;
            obi_err_i    = (k == k_rv) ? er : 1'b0;
            #1;
            exp_req = !forb && (k >= 1) && (k <= k_gnt);
            chk("dm_gnt",    32'(dm_gnt_o),    32'(k == 0));
            chk("obi_req",   32'(obi_req_o),   32'(exp_req));
            chk("dm_rvalid", 32'(dm_rvalid_o), 32'(k == resp_k));
            if (exp_req) begin
                chk("obi_addr",  obi_addr_o,       addr & 32'hFFFF_FFFC);
                chk("obi_we",    32'(obi_we_o),    32'(we));
                chk("obi_be",    32'(obi_be_o),    32'(be));
                chk("obi_wdata", obi_wdata_o,      wdata);
            end
            if (k == resp_k) begin
                chk("dm_rdata",     dm_rdata_o,          exp_rdata);
                chk("dm_err",       32'(dm_err_o),       32'(exp_err));
                chk("dm_other_err", 32'(dm_other_err_o), 32'(forb || tmo));
            end
        end
        @(posedge clk_i);
        #1;
        dm_req_i     = 1'b0;
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_err_i    = 1'b0;
        $display("txn addr=%08h we=%0d be=%h g=%0d r=%0d kind=%s resp_cycle=%0d",
                 addr, we, be, g, r, forb ? "forbidden" : (tmo ? "timeout" : "normal"), resp_k);
    endtask

    // Reset while a read is waiting for its response, then check the reset image.
    task automatic reset_in_wait_r();
        @(posedge clk_i);
        #1;
        dm_req_i   = 1'b1;
        dm_addr_i  = 32'h0001_0010;
        dm_we_i    = 1'b0;
        dm_be_i    = 4'hF;
        dm_wdata_i = 32'hA5A5_A5A5;
        #1;
        chk("rst_seq.gnt", 32'(dm_gnt_o), 32'd1);
        @(posedge clk_i);
        #1;
        dm_req_i  = 1'b0;
        obi_gnt_i = 1'b1;
        #1;
        chk("rst_seq.req", 32'(obi_req_o), 32'd1);
        @(posedge clk_i);
        #1;
        obi_gnt_i = 1'b0;
        rst_i     = 1'b1;
        #1;
        chk("rst_seq.req_low", 32'(obi_req_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        chk_all_zero("rst_wait_r");
        $display("txn reset asserted during wait for response");
    endtask

    initial begin
        logic [31:0] a;
        rst_i        = 1'b1;
        dm_req_i     = 1'b0;
        dm_addr_i    = '0;
        dm_we_i      = 1'b0;
        dm_be_i      = '0;
        dm_wdata_i   = '0;
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_rdata_i  = '0;
        obi_err_i    = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        chk_all_zero("reset");

        // Directed scenarios.
        run_txn(32'h0001_0004, 1'b0, 4'hF, 32'h0,         0, 1, 32'hDEAD_BEEF, 1'b0);
        run_txn(32'h0001_0008, 1'b1, 4'h3, 32'h1234_5678, 5, 1, 32'hFFFF_FFFF, 1'b0);
        run_txn(32'h0001_000C, 1'b0, 4'hF, 32'h0,         1, 2, 32'h0BAD_0BAD, 1'b1);
        run_txn(DBG_BASE + 32'h10, 1'b0, 4'hF, 32'h0,     0, 1, 32'h1111_1111, 1'b0);
        run_txn(DBG_BASE - 32'h4,  1'b0, 4'h1, 32'h0,     0, 1, 32'h2222_2222, 1'b0);
        run_txn(DBG_BASE + DBG_SIZE - 32'h1, 1'b1, 4'h0, 32'h3, 0, 1, 32'h0, 1'b0);
        run_txn(DBG_BASE + DBG_SIZE, 1'b0, 4'h0, 32'h0,   2, 3, 32'h3333_3333, 1'b0);
        run_txn(32'h0002_0000, 1'b0, 4'hF, 32'h0,        25, 3, 32'h4444_4444, 1'b0);
        run_txn(32'h0001_0004, 1'b0, 4'hF, 32'h0,         0, 1, 32'h5555_5555, 1'b0);
        run_txn(32'h0002_0004, 1'b0, 4'hF, 32'h0,         2, T - 3, 32'h6666_6666, 1'b0);
        run_txn(32'h0002_0008, 1'b0, 4'hF, 32'h0,         2, T - 2, 32'h7777_7777, 1'b0);
        run_txn(32'h0002_000C, 1'b1, 4'h8, 32'h9,     T - 2, 1, 32'h8888_8888, 1'b0);
        reset_in_wait_r();
        run_txn(32'h0001_0004, 1'b0, 4'hF, 32'h0,         0, 1, 32'hCAFE_F00D, 1'b0);

        // Randomized accesses.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = DBG_BASE + 32'($urandom_range(0, 32'hFFF));
            end else begin
                a = $urandom;
            end
            run_txn(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                    int'($urandom_range(0, 18)), int'($urandom_range(1, 18)), $urandom,
                    1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
